// File: rtl/serial_to_parallel_stream_pkg.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_stream_pkg
// Shared types and helpers for the serial-to-parallel stream packer.
//   beat_order_e : where beat k of a word lands in the packed output
//   slot_offset  : bit offset of beat k inside the packed word
//   cnt_width    : width of a beat count that can hold 0..ratio
// -----------------------------------------------------------------------------
package serial_to_parallel_stream_pkg;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } beat_order_e;

    // Bit offset of beat k: LSB order fills from bit 0 upward, MSB order
    // fills from the top slot downward.
    function automatic int slot_offset(input int k, input int ratio,
                                       input int in_w, input beat_order_e order);
        return (order == ORDER_MSB_FIRST) ? (ratio - 1 - k) * in_w : k * in_w;
    endfunction

    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

endpackage

// File: rtl/serial_to_parallel_stream_out_reg.sv
// -----------------------------------------------------------------------------
// s2p_out_reg
// Single-entry valid/ready holding register for a completed word.
// Optional build macro: SERIAL_TO_PARALLEL_STREAM_PARITY_EN adds a parity field.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   load             capture load_* this cycle (only issued when accept=1)
//   load_data/count/last[/parity]  word fields to capture
//   ready            downstream consumer ready
//   accept           register can take a new word: !valid || ready
//   valid            word held and presented downstream
//   data/count/last[/parity]       held word fields
// -----------------------------------------------------------------------------
module s2p_out_reg #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              load_last,
`ifdef SERIAL_TO_PARALLEL_STREAM_PARITY_EN
    input  logic              load_parity,
    output logic              parity,
`endif
    input  logic              ready,
    output logic              accept,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  count,
    output logic              last
);

    // Combinational from ready only, so upstream sees space the same cycle
    // the consumer drains the held word.
    assign accept = !valid || ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 1'b0;
            data   <= '0;
            count  <= '0;
            last   <= 1'b0;
`ifdef SERIAL_TO_PARALLEL_STREAM_PARITY_EN
            parity <= 1'b0;
`endif
        end else if (load) begin
            valid  <= 1'b1;
            data   <= load_data;
            count  <= load_count;
            last   <= load_last;
`ifdef SERIAL_TO_PARALLEL_STREAM_PARITY_EN
            parity <= load_parity;
`endif
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_to_parallel_stream.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_stream
// Packs RATIO beats of IN_W bits into one IN_W*RATIO word with valid/ready on
// both sides. in_last closes a word early; out_count reports the beat count.
// Optional build macro: SERIAL_TO_PARALLEL_STREAM_PARITY_EN adds out_parity
// (XOR reduction of out_data, registered with it).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   input beat handshake; in_data beat, in_last early close
//   out_valid/out_ready output word handshake
//   out_data            packed word, unfilled slots zero
//   out_count           beats in out_data, 1..RATIO
//   out_last            word was closed by in_last
// -----------------------------------------------------------------------------
module serial_to_parallel_stream
    import serial_to_parallel_stream_pkg::*;
#(
    parameter  int IN_W      = 1,
    parameter  int RATIO     = 8,
    parameter  int MSB_FIRST = 0,
    localparam int OUT_W     = IN_W * RATIO,
    localparam int CNT_W     = cnt_width(RATIO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
`ifdef SERIAL_TO_PARALLEL_STREAM_PARITY_EN
    output logic             out_parity,
`endif
    output logic             out_last
);

    localparam beat_order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] merged;
    logic             beat_fire;
    logic             word_done;

    assign beat_fire = in_valid && in_ready;
    assign word_done = beat_fire && ((cnt == CNT_W'(RATIO - 1)) || in_last);

    // Accumulator with the current beat dropped into its slot; this is both
    // the next accumulator value and the word handed to the output register.
    // NOTE: always_comb assigns a full default first so no latch is inferred.
    always_comb begin
        merged = acc;
        merged[slot_offset(int'(cnt), RATIO, IN_W, ORDER) +: IN_W] = in_data;
    end

    // NOTE: the accumulator is reset too, so a word cut short by reset can
    // never leak stale bits into the next word's unfilled slots.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (beat_fire) begin
            if (word_done) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                acc <= merged;
            end
        end
    end

    s2p_out_reg #(
        .DATA_W (OUT_W),
        .CNT_W  (CNT_W)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (word_done),
        .load_data   (merged),
        .load_count  (cnt + CNT_W'(1)),
        .load_last   (in_last),
`ifdef SERIAL_TO_PARALLEL_STREAM_PARITY_EN
        .load_parity (^merged),
        .parity      (out_parity),
`endif
        .ready       (out_ready),
        .accept      (in_ready),
        .valid       (out_valid),
        .data        (out_data),
        .count       (out_count),
        .last        (out_last)
    );

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// -----------------------------------------------------------------------------
// tb_serial_to_parallel_stream
// Three instances: a_* is IN_W=1/RATIO=8/LSB order; m_* and l_* are
// IN_W=4/RATIO=4 with MSB and LSB order, sharing the q_* input stimulus.
// -----------------------------------------------------------------------------
module tb_serial_to_parallel_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 1-bit x 8 instance
    logic       a_in_valid = 0, a_in_last = 0, a_out_ready = 0;
    logic [0:0] a_in_data = '0;
    logic       a_in_ready, a_out_valid, a_out_last;
    logic [7:0] a_out_data;
    logic [3:0] a_out_count;

    // 4-bit x 4 instances, shared inputs
    logic        q_in_valid = 0, q_in_last = 0, q_out_ready = 0;
    logic [3:0]  q_in_data = '0;
    logic        m_in_ready, m_out_valid, m_out_last;
    logic        l_in_ready, l_out_valid, l_out_last;
    logic [15:0] m_out_data, l_out_data;
    logic [2:0]  m_out_count, l_out_count;
`ifdef SERIAL_TO_PARALLEL_STREAM_PARITY_EN
    logic a_out_parity, m_out_parity, l_out_parity;
`endif

    serial_to_parallel_stream #(.IN_W(1), .RATIO(8), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_count(a_out_count),
`ifdef SERIAL_TO_PARALLEL_STREAM_PARITY_EN
        .out_parity(a_out_parity),
`endif
        .out_last(a_out_last));

    serial_to_parallel_stream #(.IN_W(4), .RATIO(4), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(q_in_valid), .in_ready(m_in_ready),
        .in_data(q_in_data), .in_last(q_in_last), .out_valid(m_out_valid),
        .out_ready(q_out_ready), .out_data(m_out_data), .out_count(m_out_count),
`ifdef SERIAL_TO_PARALLEL_STREAM_PARITY_EN
        .out_parity(m_out_parity),
`endif
        .out_last(m_out_last));

    serial_to_parallel_stream #(.IN_W(4), .RATIO(4), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .in_valid(q_in_valid), .in_ready(l_in_ready),
        .in_data(q_in_data), .in_last(q_in_last), .out_valid(l_out_valid),
        .out_ready(q_out_ready), .out_data(l_out_data), .out_count(l_out_count),
`ifdef SERIAL_TO_PARALLEL_STREAM_PARITY_EN
        .out_parity(l_out_parity),
`endif
        .out_last(l_out_last));

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic d, input logic last);
        a_in_valid = 1'b1; a_in_data = d; a_in_last = last;
        tick();
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic q_beat(input logic [3:0] d, input logic last);
        q_in_valid = 1'b1; q_in_data = d; q_in_last = last;
        tick();
        q_in_valid = 1'b0; q_in_last = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        int         count;
        logic       last;
    } word_t;

    word_t      exp_q[$];
    word_t      w;
    logic [7:0] cur_word;
    int         cur_beats;
    int         words_seen;
    int         cycles;
    int         bits_in;
    int         bits_out;
    int         queued_bits;
    logic [15:0] held;

    initial begin
        // ---------------- reset values ----------------
        #2 rst = 1'b0;
        #1;
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_data",  a_out_data,  0);
        check("rst_a_count", a_out_count, 0);
        check("rst_a_last",  a_out_last,  0);
        check("rst_l_valid", l_out_valid, 0);
        check("rst_l_count", l_out_count, 0);
        check("rst_a_ready", a_in_ready,  1);
        #4 rst = 1'b1;
        tick();

        // ---------------- 1: 1-bit x 8, LSB order ----------------
        a_out_ready = 1'b1;
        a_beat(1, 0); a_beat(0, 0); a_beat(1, 0); a_beat(1, 0);
        a_beat(0, 0); a_beat(0, 0); a_beat(0, 0);
        check("t1_not_early", a_out_valid, 0);
        a_beat(0, 0);
        check("t1_valid", a_out_valid, 1);
        check("t1_data",  a_out_data,  8'h0D);
        check("t1_count", a_out_count, 8);
        check("t1_last",  a_out_last,  0);
        tick();
        check("t1_drained", a_out_valid, 0);

        // ---------------- 2: beat order ----------------
        q_out_ready = 1'b1;
        q_beat(4'hA, 0); q_beat(4'hB, 0); q_beat(4'hC, 0);
        check("t2_not_early", m_out_valid, 0);
        q_beat(4'hD, 0);
        check("t2_m_valid", m_out_valid, 1);
        check("t2_m_data",  m_out_data,  16'hABCD);
        check("t2_l_data",  l_out_data,  16'hDCBA);
        check("t2_l_count", l_out_count, 4);
        check("t2_l_last",  l_out_last,  0);

        // ---------------- 3: early terminate ----------------
        q_beat(4'h3, 0);
        check("t3_consumed", l_out_valid, 0);
        q_beat(4'h5, 1);
        check("t3_l_data",  l_out_data,  16'h0053);
        check("t3_m_data",  m_out_data,  16'h3500);
        check("t3_l_count", l_out_count, 2);
        check("t3_l_last",  l_out_last,  1);
        q_beat(4'h1, 0); q_beat(4'h2, 0); q_beat(4'h3, 0); q_beat(4'h4, 0);
        check("t3_next_l",     l_out_data,  16'h4321);
        check("t3_next_m",     m_out_data,  16'h1234);
        check("t3_next_count", l_out_count, 4);
        check("t3_next_last",  l_out_last,  0);

        // in_last on the first beat, back-to-back with out_ready=1
        q_beat(4'h7, 1);
        check("single_l",     l_out_data,  16'h0007);
        check("single_m",     m_out_data,  16'h7000);
        check("single_count", l_out_count, 1);
        q_beat(4'h9, 1);
        check("b2b_valid", l_out_valid, 1);
        check("b2b_l",     l_out_data,  16'h0009);
        check("b2b_m",     m_out_data,  16'h9000);
        tick();

        // ---------------- 4: backpressure ----------------
        q_out_ready = 1'b0;
        q_beat(4'h6, 0); q_beat(4'h7, 0); q_beat(4'h8, 0); q_beat(4'h9, 0);
        check("t4_held_valid", l_out_valid, 1);
        check("t4_held_data",  l_out_data,  16'h9876);
        held = l_out_data;
        q_in_valid = 1'b1; q_in_data = 4'hF; q_in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t4_in_ready_low", {m_in_ready, l_in_ready}, 2'b00);
            tick();
            check("t4_stable_data",  l_out_data,  held);
            check("t4_stable_cnt",   l_out_count, 4);
            check("t4_stable_valid", l_out_valid, 1);
        end
        q_in_valid = 1'b0; q_in_last = 1'b0;
        q_out_ready = 1'b1;
        #1;
        check("t4_ready_same_cycle", l_in_ready, 1);
        tick();
        check("t4_consumed", l_out_valid, 0);

        // ---------------- 6: reset mid-word ----------------
        q_out_ready = 1'b0;
        q_beat(4'h1, 0); q_beat(4'h2, 0); q_beat(4'h3, 0); q_beat(4'h4, 0);
        check("t6_q_held", l_out_valid, 1);
        a_beat(1, 0); a_beat(1, 0); a_beat(1, 0);
        #2 rst = 1'b0;
        #1;
        check("t6_a_valid", a_out_valid, 0);
        check("t6_a_data",  a_out_data,  0);
        check("t6_a_count", a_out_count, 0);
        check("t6_a_last",  a_out_last,  0);
        check("t6_l_valid", l_out_valid, 0);
        check("t6_l_data",  l_out_data,  0);
        #3 rst = 1'b1;
        tick();
        check("t6_no_output", a_out_valid, 0);
        for (int i = 0; i < 7; i++) a_beat(1, 0);
        check("t6_no_residue_cnt", a_out_valid, 0);
        a_beat(1, 0);
        check("t6_ff_data",  a_out_data,  8'hFF);
        check("t6_ff_count", a_out_count, 8);
        q_out_ready = 1'b1;
        q_beat(4'h1, 0); q_beat(4'h2, 0); q_beat(4'h3, 0); q_beat(4'h4, 1);
        check("t6_full_last_l", l_out_data,  16'h4321);
        check("t6_full_last_c", l_out_count, 4);
        check("t6_full_last_f", l_out_last,  1);
        tick();

        // ---------------- 5: random traffic vs model ----------------
        cur_word = '0; cur_beats = 0; words_seen = 0; cycles = 0;
        bits_in = 0; bits_out = 0;
        while (words_seen < 1000 && cycles < 60000) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = 1'($urandom);
            a_in_last   = ($urandom_range(0, 15) == 0);
            a_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_ready_rule", a_in_ready, !a_out_valid || a_out_ready);
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_word", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("rnd_word", {a_out_data, a_out_count, a_out_last},
                          {w.data, 4'(w.count), w.last});
`ifdef SERIAL_TO_PARALLEL_STREAM_PARITY_EN
                    check("rnd_parity", a_out_parity, ^w.data);
`endif
                end
                words_seen++;
                bits_out += int'(a_out_count);
            end
            if (a_in_valid && a_in_ready) begin
                cur_word = cur_word | (8'(a_in_data) << cur_beats);
                cur_beats++;
                bits_in++;
                if (cur_beats == 8 || a_in_last) begin
                    exp_q.push_back('{data: cur_word, count: cur_beats, last: a_in_last});
                    cur_word = '0;
                    cur_beats = 0;
                end
            end
            tick();
            cycles++;
        end
        check("rnd_words_done", words_seen, 1000);
        queued_bits = 0;
        foreach (exp_q[i]) queued_bits += exp_q[i].count;
        check("rnd_bit_conservation", bits_in, bits_out + queued_bits + cur_beats);
        a_in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
